// File: rtl/mutative_tag_pkg.sv
// Shared types for the mutative tag controller: default geometry, request opcodes,
// tag-entry layout and controller states.
package mutative_tag_pkg;

  localparam int DEF_INDEX_W = 7;
  localparam int DEF_TAG_W   = 19;

  typedef enum logic [1:0] {
    OP_LOOKUP       = 2'b00,
    OP_WRITE        = 2'b01,
    OP_INVAL        = 2'b10,
    OP_LOOKUP_DIRTY = 2'b11
  } op_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_RMW  = 2'b10
  } state_e;

  function automatic logic is_lookup(input op_e op);
    return (op == OP_LOOKUP) || (op == OP_LOOKUP_DIRTY);
  endfunction

endpackage

// File: rtl/mutative_tag_ctrl.sv
// Tag-SRAM controller: lookup/write/invalidate with a read-modify-write dirty-set.
// Define MUTATIVE_TAG_INIT_EN to clear every SRAM entry after reset before accepting requests.
module mutative_tag_ctrl
  import mutative_tag_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               req_dirty,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic               rsp_dirty,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               init_done,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [INDEX_W-1:0] sram_addr0,
  output logic [TAG_W+1:0]   sram_din0,
  input  logic [TAG_W+1:0]   sram_dout0
);

`ifdef MUTATIVE_TAG_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e state, state_nxt;
  op_e    op;
  logic   run_q;
  logic   accept;
  logic   vld_p0;
  logic [TAG_W-1:0]   tag_p0;
  logic [INDEX_W-1:0] idx_p0;
  logic               rd_valid, rd_dirty, hit_now;
  logic [TAG_W-1:0]   rd_tag;

  assign op       = op_e'(req_op);
  assign rd_valid = sram_dout0[TAG_W+1];
  assign rd_dirty = sram_dout0[TAG_W];
  assign rd_tag   = sram_dout0[TAG_W-1:0];
  assign hit_now  = rd_valid && (rd_tag == tag_p0);

`ifdef MUTATIVE_TAG_INIT_EN
  logic [INDEX_W-1:0] init_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx <= '0;
    end else if (run_q && state == ST_INIT) begin
      init_idx <= init_idx + 1'b1;
    end
  end

  assign init_done = (state != ST_INIT);
`else
  assign init_done = 1'b1;
`endif

  // run_q holds off every SRAM access for the first edge after reset release
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = req_index;
    sram_din0  = '0;
    if (run_q) begin
      case (state)
`ifdef MUTATIVE_TAG_INIT_EN
        ST_INIT: begin
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = init_idx;
          if (init_idx == '1) state_nxt = ST_IDLE;
        end
`endif
        ST_IDLE: begin
          req_ready = 1'b1;
          accept    = req_valid;
          if (req_valid) begin
            sram_csb0 = 1'b0;
            case (op)
              OP_WRITE: begin
                sram_web0 = 1'b0;
                sram_din0 = {1'b1, req_dirty, req_tag};
              end
              OP_INVAL:        sram_web0 = 1'b0;
              OP_LOOKUP_DIRTY: state_nxt = ST_RMW;
              default:         sram_web0 = 1'b1;
            endcase
          end
        end
        ST_RMW: begin
          state_nxt = ST_IDLE;
          if (hit_now && !rd_dirty) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = idx_p0;
            sram_din0  = {2'b11, tag_p0};
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // p0: read issued, SRAM data arrives; p1: registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      run_q     <= 1'b0;
      vld_p0    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_dirty <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      state     <= state_nxt;
      run_q     <= 1'b1;
      vld_p0    <= accept && is_lookup(op);
      rsp_valid <= vld_p0;
      if (vld_p0) begin
        rsp_hit   <= hit_now;
        rsp_dirty <= rd_dirty;
        rsp_tag   <= rd_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_p0 <= req_tag;
      idx_p0 <= req_index;
    end
  end

endmodule

// File: tb/tb_mutative_tag_ctrl.sv
// Self-checking bench for mutative_tag_ctrl with a tag-SRAM model and an entry-level reference model.
module tb_mutative_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_index;
  logic [18:0] req_tag;
  logic        req_dirty;
  logic        rsp_valid, rsp_hit, rsp_dirty;
  logic [18:0] rsp_tag;
  logic        init_done;
  logic        sram_csb0, sram_web0;
  logic [6:0]  sram_addr0;
  logic [20:0] sram_din0;
  logic [20:0] sram_dout0;

  mutative_tag_ctrl #(.INDEX_W(7), .TAG_W(19)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_tag(req_tag), .req_dirty(req_dirty),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dirty(rsp_dirty), .rsp_tag(rsp_tag),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // SRAM macro: one port, read data valid the cycle after the read edge
  logic [20:0] sram_mem [0:127];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) sram_mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= sram_mem[sram_addr0];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: entry array plus queue of pending responses
  typedef struct {
    int          due;
    logic        hit;
    logic        dirty;
    logic [18:0] tag;
  } exp_t;

  logic [20:0] ref_mem [0:127];
  exp_t        rq[$];
  exp_t        e;
  logic [20:0] ent;
  logic        busy = 1'b0;
  logic        exp_rdy, mhit;
  logic        chk_en = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      exp_rdy = !busy;
      chk("req_ready", req_ready, exp_rdy);
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_hit", rsp_hit, e.hit);
        chk("rsp_dirty", rsp_dirty, e.dirty);
        chk("rsp_tag", rsp_tag, e.tag);
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
      end
      busy = 1'b0;
      if (req_valid && exp_rdy) begin
        ent = ref_mem[req_index];
        case (req_op)
          2'b01: ref_mem[req_index] = {1'b1, req_dirty, req_tag};
          2'b10: ref_mem[req_index] = '0;
          default: begin
            mhit = ent[20] && (ent[18:0] == req_tag);
            rq.push_back('{cyc + 2, mhit, ent[19], ent[18:0]});
            if (req_op == 2'b11) begin
              busy = 1'b1;
              if (mhit && !ent[19]) ref_mem[req_index] = {2'b11, req_tag};
            end
          end
        endcase
      end
    end
  end

  task automatic wr(input logic [1:0] op, input logic [6:0] idx, input logic [18:0] tag,
                    input logic d);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_index = idx; req_tag = tag; req_dirty = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic lk(input logic [1:0] op, input logic [6:0] idx, input logic [18:0] tag,
                    input logic ehit, input logic edirty, input logic [18:0] etag,
                    input logic ermw);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_index = idx; req_tag = tag; req_dirty = 1'b0;
    @(negedge clk);
    chk("lit_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("lit_rsp_early", rsp_valid, 0);
    if (op == 2'b11) begin
      chk("lit_rmw_ready", req_ready, 0);
      chk("lit_rmw_ctl", {sram_csb0, sram_web0}, ermw ? 2'b00 : 2'b11);
      if (ermw) chk("lit_rmw_data", {sram_addr0, sram_din0}, {idx, 2'b11, tag});
    end
    @(negedge clk);
    chk("lit_rsp_valid", rsp_valid, 1);
    chk("lit_rsp_hit", rsp_hit, ehit);
    chk("lit_rsp_dirty", rsp_dirty, edirty);
    chk("lit_rsp_tag", rsp_tag, etag);
  endtask

`ifdef MUTATIVE_TAG_INIT_EN
  task automatic sweep(input int abort_at);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (!sram_csb0) break;
    end
    chk("sweep_start", sram_csb0, 0);
    for (int i = 0; i < 128; i++) begin
      if (i > 0) @(negedge clk);
      chk("sweep_wr", {init_done, req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0},
          {4'b0000, 7'(i), 21'd0});
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", {init_done, sram_csb0, sram_web0}, 3'b011);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("init_done", {init_done, req_ready, sram_csb0}, 3'b111);
  endtask
`endif

  logic [18:0] rtag;

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_dout0 = '0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_index = '0; req_tag = '0; req_dirty = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rsp", {rsp_valid, rsp_hit, rsp_dirty, rsp_tag}, 22'd0);
    chk("rst_sram_ctl", {sram_csb0, sram_web0}, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef MUTATIVE_TAG_INIT_EN
    sweep(60);
    sweep(-1);
`else
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", {init_done, req_ready, sram_csb0}, 3'b111);
`endif
    chk_en = 1'b1;

    wr(2'b01, 7'd5, 19'h1ABCD, 1'b0);
    lk(2'b00, 7'd5, 19'h1ABCD, 1'b1, 1'b0, 19'h1ABCD, 1'b0);
    lk(2'b00, 7'd5, 19'h00001, 1'b0, 1'b0, 19'h1ABCD, 1'b0);
    lk(2'b11, 7'd5, 19'h1ABCD, 1'b1, 1'b0, 19'h1ABCD, 1'b1);
    lk(2'b00, 7'd5, 19'h1ABCD, 1'b1, 1'b1, 19'h1ABCD, 1'b0);
    lk(2'b11, 7'd5, 19'h1ABCD, 1'b1, 1'b1, 19'h1ABCD, 1'b0);
    wr(2'b10, 7'd5, 19'h00000, 1'b0);
    lk(2'b00, 7'd5, 19'h1ABCD, 1'b0, 1'b0, 19'h00000, 1'b0);

    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 3))
        0: rtag = 19'h1ABCD;
        1: rtag = 19'h00001;
        2: rtag = 19'h7FFFF;
        default: rtag = 19'h00002;
      endcase
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 2'($urandom_range(0, 3));
      req_index = 7'($urandom_range(0, 7));
      req_tag   = rtag;
      req_dirty = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_queue", rq.size(), 0);
    for (int i = 0; i < 128; i++) chk("final_mem", sram_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mutative_tag_ctrl.md
MUTATIVE_TAG_CTRL -- requirements
Module: mutative_tag_ctrl

Interface
REQ-001 Parameter INDEX_W SHALL be: default 7, set index width (128 sets).
REQ-002 Parameter TAG_W SHALL be: default 19, stored tag width; SRAM word = TAG_W+2 = 21.
REQ-003 Port clk: input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n: input, 1; SHALL be an asynchronous, active-low reset.
REQ-005 Port req_valid: input, 1, request present.
REQ-006 Port req_ready: output, 1, controller can accept a request.
REQ-007 Port req_op: input, 2: 00 LOOKUP, 01 WRITE, 10 INVAL, 11 LOOKUP_DIRTY.
REQ-008 Ports req_index [INDEX_W-1:0], req_tag [TAG_W-1:0], req_dirty [1]: inputs, request fields.
REQ-009 Ports rsp_valid [1], rsp_hit [1], rsp_dirty [1], rsp_tag [TAG_W-1:0]: outputs, lookup result (stored entry).
REQ-010 Port init_done: output, 1, SRAM clear sweep complete.
REQ-011 Ports sram_csb0 [1], sram_web0 [1], sram_addr0 [INDEX_W-1:0], sram_din0 [TAG_W+1:0]: outputs to the tag SRAM macro, all active-low controls.
REQ-012 Port sram_dout0: input, TAG_W+2, SRAM read data, valid the cycle after the read edge.

Function
REQ-013 Entry format SHALL be {valid[TAG_W+1], dirty[TAG_W], tag[TAG_W-1:0]}.
REQ-014 FSM states SHALL be INIT, IDLE, RMW; transitions INIT->IDLE on sweep done, IDLE->RMW on accepted LOOKUP_DIRTY, RMW->IDLE unconditionally.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
REQ-016 SRAM controls SHALL be combinational from the accepting cycle: csb0=0, addr0=req_index; web0=0 for WRITE/INVAL, 1 for LOOKUP/LOOKUP_DIRTY; csb0=1 in any cycle without an accept or an INIT/RMW access.
REQ-017 WRITE SHALL drive din0={1,req_dirty,req_tag}; INVAL SHALL drive din0=0; neither produces a response.
REQ-018 For LOOKUP/LOOKUP_DIRTY accepted at edge E, the controller SHALL register hit=(dout.valid && dout.tag==captured req_tag) at edge E+1 and present rsp_valid=1 for exactly the cycle after E+1 (latency 2), with rsp_dirty/rsp_tag equal to the stored entry.
REQ-019 Back-to-back requests SHALL be accepted every cycle in IDLE; a read following a write to the same index SHALL return the new entry.
REQ-020 In RMW (cycle after LOOKUP_DIRTY accept) the controller SHALL, if hit && !dirty, write {1,1,tag} to the same index, else keep csb0=1.
REQ-021 rsp_valid SHALL have no backpressure; the consumer SHALL always sample it.

Reset
REQ-022 Reset SHALL force rsp_valid=0, rsp_hit=0, rsp_dirty=0, rsp_tag=0, sram_csb0=1, sram_web0=1, and the state to INIT (or IDLE without the macro).
REQ-023 Reset asserted mid-sweep or mid-RMW SHALL abort it; the sweep SHALL restart from index 0, and no RMW write completes.

Configuration
REQ-024 Macro MUTATIVE_TAG_INIT_EN defined: INIT SHALL write 0 to indices 0..127, one per cycle (128 cycles), with init_done=0 and req_ready=0, then init_done=1.
REQ-025 Macro MUTATIVE_TAG_INIT_EN undefined: no sweep; the FSM SHALL reset to IDLE and init_done SHALL be constant 1.

Structure
REQ-026 Package mutative_tag_pkg SHALL hold INDEX_W/TAG_W defaults, the op enum, the entry struct, and the FSM state enum.
REQ-027 The block SHALL be a single module with no sub-module; the SRAM macro is instantiated by the parent.

Verification
REQ-028 Reset with the macro -> exactly 128 consecutive writes of 0 to addr 0..127, then init_done=1 and req_ready=1.
REQ-029 WRITE idx 5 tag 0x1ABCD dirty 0, then LOOKUP idx 5 tag 0x1ABCD -> rsp_valid 2 cycles after accept, hit=1, dirty=0.
REQ-030 LOOKUP idx 5 tag 0x00001 -> hit=0, rsp_tag=0x1ABCD; INVAL idx 5 then LOOKUP -> hit=0.
REQ-031 LOOKUP_DIRTY hit on a clean entry -> req_ready=0 for one cycle and SRAM write {1,1,tag}; a subsequent LOOKUP gives dirty=1.
REQ-032 rst_n pulsed low at sweep index 60 -> sweep restarts at 0 and completes 128 writes.
